// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to replace the iterative multiply with a single-cycle multiplier.
module muldiv_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam logic [2:0]      OP_MUL    = 3'b000;
  localparam logic [2:0]      OP_MULH   = 3'b001;
  localparam logic [2:0]      OP_MULHSU = 3'b010;
  localparam logic [XLEN-1:0] MIN_INT   = {1'b1, {(XLEN-1){1'b0}}};
`ifdef MULDIV_FAST_MUL_EN
  localparam logic FAST_MUL = 1'b1;
`else
  localparam logic FAST_MUL = 1'b0;
`endif

  state_t              state_q, state_d;
  logic [2:0]          op_q, op_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                neg_q, neg_d;
  logic                dz_q, dz_d;
  logic                ovf_q, ovf_d;
  logic [XLEN-1:0]     result_q, result_d;

  logic                a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]     a_mag, b_mag;
  logic                div_zero, div_ovf, neg_in, fast_in, accept;
  logic [XLEN:0]       mul_sum;
  logic [2*XLEN-1:0]   mul_next, div_next, mul_prod;
  logic [XLEN-1:0]     div_shift, div_rem, lo_fix, hi_fix, fix_res;
  logic                div_ge;
`ifdef MULDIV_FAST_MUL_EN
  logic                fm_a_ext, fm_b_ext;
  logic [2*XLEN-1:0]   fm_a, fm_b;
`endif

  // Operand decode: magnitudes, final-sign flag and the fast-path special cases.
  always_comb begin
    a_signed = op[2] ? ~op[0] : (op == OP_MULH || op == OP_MULHSU);
    b_signed = op[2] ? ~op[0] : (op == OP_MULH);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    a_mag    = a_neg ? -a : a;
    b_mag    = b_neg ? -b : b;
    div_zero = op[2] & (b == '0);
    div_ovf  = op[2] & ~op[0] & (a == MIN_INT) & (b == '1);
    neg_in   = (op[2] & op[1]) ? a_neg : (a_neg ^ b_neg);
    fast_in  = div_zero | div_ovf | (FAST_MUL & ~op[2]);
    accept   = in_valid & in_ready & ~flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = fast_in ? FIX : CALC;
      CALC: if (flush) state_d = IDLE;
            else if (cnt_q == CNT_W'(XLEN-1)) state_d = FIX;
      FIX:  state_d = flush ? IDLE : DONE;
      DONE: if (flush || out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
  end

  // One radix-2 step; the divide carry-out bit guarantees the subtract fits in XLEN bits.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
    mul_next  = {mul_sum, acc_q[XLEN-1:1]};
    div_shift = {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]};
    div_ge    = acc_q[2*XLEN-1] | (div_shift >= mcand_q);
    div_rem   = div_ge ? (div_shift - mcand_q) : div_shift;
    div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};
  end

  always_comb begin
    lo_fix = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    hi_fix = neg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
`ifdef MULDIV_FAST_MUL_EN
    fm_a_ext = (op_q == OP_MULH || op_q == OP_MULHSU) & acc_q[XLEN-1];
    fm_b_ext = (op_q == OP_MULH) & acc_q[2*XLEN-1];
    fm_a     = {{XLEN{fm_a_ext}}, acc_q[XLEN-1:0]};
    fm_b     = {{XLEN{fm_b_ext}}, acc_q[2*XLEN-1:XLEN]};
    mul_prod = fm_a * fm_b;
`else
    mul_prod = neg_q ? -acc_q : acc_q;
`endif
    if (op_q[2]) begin
      if (dz_q)       fix_res = op_q[1] ? acc_q[XLEN-1:0] : '1;
      else if (ovf_q) fix_res = op_q[1] ? '0 : MIN_INT;
      else            fix_res = op_q[1] ? hi_fix : lo_fix;
    end else begin
      fix_res = (op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN];
    end
  end

  // Fast-path ops keep the raw operands {b, a} in the accumulator for the fix-up stage.
  always_comb begin
    op_d     = op_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    cnt_d    = cnt_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    case (state_q)
      IDLE: if (accept) begin
        op_d    = op;
        neg_d   = neg_in;
        dz_d    = div_zero;
        ovf_d   = div_ovf;
        cnt_d   = '0;
        acc_d   = fast_in ? {b, a} : {{XLEN{1'b0}}, a_mag};
        mcand_d = b_mag;
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q + 1'b1;
      end
      FIX: if (!flush) result_d = fix_res;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
    end else begin
      op_q     <= op_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      cnt_q    <= cnt_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M corner cases plus randomized
// operations compared against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int check_cnt = 0;
  int pass_cnt  = 0;

  muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
  endtask

  // Architectural RV32M results computed with plain 64-bit and 32-bit arithmetic.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    int          xi, yi;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'b0, x});
    uy = longint'({32'b0, y});
    xi = int'(x);
    yi = int'(y);
    ref_model = '0;
    case (o)
      3'd0: begin p = sx * sy; ref_model = p[31:0];  end
      3'd1: begin p = sx * sy; ref_model = p[63:32]; end
      3'd2: begin p = sx * uy; ref_model = p[63:32]; end
      3'd3: begin p = ux * uy; ref_model = p[63:32]; end
      3'd4: if (y == 0) ref_model = 32'hFFFF_FFFF;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_model = 32'h8000_0000;
            else ref_model = 32'(xi / yi);
      3'd5: ref_model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: if (y == 0) ref_model = x;
            else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) ref_model = 32'h0;
            else ref_model = 32'(xi % yi);
      default: ref_model = (y == 0) ? x : x % y;
    endcase
  endfunction

  // Edges from accept to out_valid: 1 for special cases, 33 for full iterations.
  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    bit fast;
    fast = o[2] && (y == 0 || (!o[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
`ifdef MULDIV_FAST_MUL_EN
    fast = fast || !o[2];
`endif
    return fast ? 1 : 33;
  endfunction

  // Issue one operation, wait for its result, and retire it.
  // mode 0: plain release, 1: 20 cycles of back-pressure first, 2: release with flush+out_ready.
  task automatic applyStimulus(input string tag, input logic [2:0] o, input logic [31:0] x,
                               input logic [31:0] y, input logic [31:0] expv, input int mode);
    int          want_lat;
    int          edges;
    bit          busy_ok;
    bit          stable_ok;
    logic [31:0] held;
    want_lat = exp_latency(o, x, y);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b0;
    checkOutput({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    op = 3'($urandom); a = $urandom; b = $urandom;
    edges = 0;
    busy_ok = 1'b1;
    while (out_valid !== 1'b1 && edges < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      edges++;
    end
    checkOutput({tag, "_latency"}, 64'(edges), 64'(want_lat));
    checkOutput({tag, "_result"}, 64'(result), 64'(expv));
    checkOutput({tag, "_busy"}, 64'(busy_ok), 64'd1);
    if (mode == 1) begin
      held = result;
      stable_ok = 1'b1;
      repeat (20) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || result !== held || in_ready !== 1'b0 || busy !== 1'b1) stable_ok = 1'b0;
      end
      checkOutput({tag, "_hold"}, 64'(stable_ok), 64'd1);
    end
    @(negedge clk);
    out_ready = 1'b1;
    if (mode == 2) flush = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    flush = 1'b0;
    checkOutput({tag, "_release"}, 64'({out_valid, busy, in_ready}), 64'b001);
  endtask

  // Main sequence: reset, directed cases, flush/reset disruptions, then random traffic.
  initial begin
    bit          seen;
    logic [2:0]  ro;
    logic [31:0] rx, ry;
    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
    #2;
    checkOutput("reset_outputs", 64'({out_valid, busy, in_ready}), 64'b001);
    checkOutput("reset_result", 64'(result), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    applyStimulus("mul_7_m3",      3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    applyStimulus("mulh_min",      3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    applyStimulus("mulhu_min",     3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 0);
    applyStimulus("mulhsu_m1",     3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    applyStimulus("div_m7_2",      3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
    applyStimulus("rem_m7_2",      3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
    applyStimulus("divu_100_7",    3'd5, 32'd100,        32'd7,         32'd14,        1);
    applyStimulus("remu_100_7",    3'd7, 32'd100,        32'd7,         32'd2,         0);
    applyStimulus("divu_by_zero",  3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0);
    applyStimulus("rem_by_zero",   3'd6, 32'd5,          32'd0,         32'd5,         0);
    applyStimulus("div_overflow",  3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
    applyStimulus("rem_overflow",  3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         2);

    // Flush part-way through a divide: the result must never appear.
    @(negedge clk);
    op = 3'd5; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checkOutput("flush_calc_idle", 64'({out_valid, busy, in_ready}), 64'b001);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    checkOutput("flush_no_valid", 64'(seen), 64'd0);
    applyStimulus("mul_after_flush", 3'd0, 32'd3, 32'd4, 32'd12, 0);

    // Flush in IDLE wins over a simultaneous request.
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; op = 3'd4; a = 32'd9; b = 32'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    checkOutput("flush_idle_drop", 64'({busy, in_ready}), 64'b01);

    // Asynchronous reset mid-calculation clears outputs without waiting for a clock.
    @(negedge clk);
    op = 3'd4; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_reset_ctrl", 64'({out_valid, busy}), 64'b00);
    checkOutput("async_reset_result", 64'(result), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("reset_release_idle", 64'({busy, in_ready}), 64'b01);

    // Randomized traffic; some divisors forced to zero and some operands kept small.
    for (int i = 0; i < 48; i++) begin
      ro = 3'($urandom_range(0, 7));
      rx = $urandom;
      ry = $urandom;
      if ($urandom_range(0, 7) == 0) ry = 32'd0;
      if ($urandom_range(0, 3) == 0) begin
        rx = rx % 32'd200;
        ry = {{28{ry[31]}}, ry[3:0]};
      end
      applyStimulus($sformatf("rand%0d_op%0d", i, ro), ro, rx, ry, ref_model(ro, rx, ry), i % 3);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit in the execute stage, alongside the integer ALU.
- Takes the same rs1/rs2 operands as the ALU. Its result joins the ALU result at the execute-stage result mux ahead of the EX/MEM register.
- Multi-cycle, with valid/ready handshakes on both sides. The pipeline stalls decode/execute while busy is high.
- Handles all eight M-extension ops, including the divide-by-zero and signed-overflow results the ISA defines.

Parameters:
- XLEN, 32, operand/result width; only 32 is supported.
- CNT_W, 6, iteration counter width; must hold XLEN+1.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  operands and op are valid
- in_ready  output  1  unit can accept (state IDLE)
- op  input  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  input  32  rs1 value
- b  input  32  rs2 value
- flush  input  1  abort the in-flight operation (branch mispredict/trap)
- out_valid  output  1  result is valid
- out_ready  input  1  consumer takes result
- result  output  32  final result
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE, out_valid=0, result=0, counter=0, busy=0. Internal accumulators cleared.
- Accept: on a rising edge with in_valid & in_ready, latch op, a, b and the sign flags. in_ready is combinationally (state==IDLE) only, and never depends on in_valid.
- States:
  - IDLE: accept -> CALC, or -> FIX when divisor is zero or the op is a signed overflow.
  - CALC: one radix-2 step per cycle.
    - MUL*: shift-add on 33-bit sign-extended magnitudes.
    - DIV*/REM*: restoring division on magnitudes.
    - Counter runs 0..31; at 31 -> FIX.
  - FIX: apply sign correction, select the upper/lower half or quotient/remainder, register result, set out_valid=1 -> DONE.
  - DONE: hold result and out_valid until out_ready=1, then -> IDLE with out_valid=0 on that edge.
- Latency:
  - Normal ops: out_valid high 33 rising edges after the accept edge (32 CALC + 1 FIX).
  - Fast-path ops: 1 edge after accept.
- Signedness:
  - MULH: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU: both unsigned.
  - MUL: low 32 bits (sign-agnostic).
- Sign fixup:
  - Quotient is negated iff sign(a)^sign(b) for DIV.
  - Remainder takes the sign of a for REM.
  - The 64-bit product is negated iff the effective operand signs differ.
- Divide by zero (b==0):
  - DIV/DIVU -> 32'hFFFF_FFFF.
  - REM/REMU -> a.
  - Fast path, no CALC cycles.
- Signed overflow (DIV/REM with a=32'h8000_0000, b=32'hFFFF_FFFF):
  - DIV -> 32'h8000_0000.
  - REM -> 0.
  - Fast path.
- Flush:
  - In CALC, FIX or DONE: next edge -> IDLE, out_valid=0, result is not updated.
  - In IDLE: has priority over accept, so a same-cycle in_valid is dropped.
  - Flush and out_ready in the same DONE cycle: -> IDLE; the consumer treats the result as taken.
- Back-pressure: out_ready low in DONE holds the state indefinitely and keeps result stable.
- Back-to-back: no new accept in the DONE->IDLE transition cycle. The next accept is possible on the following edge.
- Operand changes on a/b/op after the accept edge have no effect.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - MUL/MULH/MULHSU/MULHU use a single combinational 33x33 signed multiply registered in FIX, skipping CALC.
  - Multiply latency is 1 edge after accept.
  - Divide behaviour is unchanged.
- Undefined:
  - Iterative shift-add multiply with 33-edge latency.
  - No hardware multiplier is inferred.

Test Plan:
- MUL a=7, b=-3 (32'hFFFF_FFFD), out_ready=1 -> result=32'hFFFF_FFEB; out_valid exactly 33 edges after accept (1 edge with MULDIV_FAST_MUL_EN); busy high throughout.
- MULH a=32'h8000_0000, b=32'h8000_0000 -> 32'h4000_0000. MULHU on the same operands -> 32'h4000_0000. MULHSU a=-1, b=32'hFFFF_FFFF -> 32'hFFFF_FFFF.
- DIV a=-7, b=2 -> 32'hFFFF_FFFD (-3). REM -> 32'hFFFF_FFFF (-1). DIVU a=100, b=7 -> 14. REMU -> 2.
- DIVU a=5, b=0 -> 32'hFFFF_FFFF after 1 edge. REM a=5, b=0 -> 5. DIV 32'h8000_0000 / 32'hFFFF_FFFF -> 32'h8000_0000; REM on the same operands -> 0.
- Start DIVU, assert flush at CALC cycle 10 -> IDLE next edge, out_valid never rises. A fresh MUL 3x4 accepted immediately after -> 12.
- Hold out_ready=0 for 20 cycles in DONE -> result/out_valid stable, in_ready=0. Assert rst mid-CALC -> all outputs zero immediately (asynchronous), IDLE after release.
